// File: rtl/regfile_write_queue.sv
// ============================================================================
//  Module      : regfile_write_queue
//  Description : Writeback FIFO in front of the 32x32 register file. It drains
//                one entry per cycle onto the single write port and forwards
//                pending data to two read lookups. Define
//                REGFILE_WQ_COALESCE_EN to merge a push into the youngest entry
//                when both name the same register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                        clock,
    input  logic                        ctrl_reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_WIDTH-1:0]       in_reg,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        stall_drain,
    output logic                        ctrl_writeEnable,
    output logic [ADDR_WIDTH-1:0]       ctrl_writeReg,
    output logic [DATA_WIDTH-1:0]       data_writeReg,
    input  logic [ADDR_WIDTH-1:0]       lookup_regA,
    input  logic [ADDR_WIDTH-1:0]       lookup_regB,
    output logic                        hit_A,
    output logic                        hit_B,
    output logic [DATA_WIDTH-1:0]       fwd_dataA,
    output logic [DATA_WIDTH-1:0]       fwd_dataB,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty,
    output logic                        full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic [DEPTH-1:0]      r_valid;
    logic [ADDR_WIDTH-1:0] r_reg  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_coal;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = !w_empty && !stall_drain;

`ifdef REGFILE_WQ_COALESCE_EN
    logic [PW-1:0] w_youngest;
    logic          w_match;

    assign w_youngest = r_tail - PW'(1);
    assign w_match    = !w_empty && (r_reg[w_youngest] == in_reg);
    // The head leaving this cycle cannot absorb new data; allocate instead.
    assign w_coal     = in_valid && (in_reg != '0) && w_match
                        && !(w_pop && (w_youngest == r_head));
    assign in_ready   = !w_full || (in_valid && w_match);
`else
    assign w_coal     = 1'b0;
    assign in_ready   = !w_full;
`endif

    assign w_push = in_valid && in_ready && (in_reg != '0) && !w_coal;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_head          <= r_head + PW'(1);
                r_valid[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_tail          <= r_tail + PW'(1);
                r_valid[r_tail] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; every observer is gated by valid/empty.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            if (w_push) begin
                r_reg[r_tail]  <= in_reg;
                r_data[r_tail] <= in_data;
            end
`ifdef REGFILE_WQ_COALESCE_EN
            else if (w_coal) begin
                r_data[w_youngest] <= in_data;
            end
`endif
        end
    end

    assign ctrl_writeEnable = w_pop;
    assign ctrl_writeReg    = w_empty ? '0 : r_reg[r_head];
    assign data_writeReg    = w_empty ? '0 : r_data[r_head];
    assign count            = r_count;
    assign empty            = w_empty;
    assign full             = w_full;

    // Scan oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        hit_A     = 1'b0;
        hit_B     = 1'b0;
        fwd_dataA = '0;
        fwd_dataB = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[r_head + PW'(k)] && (lookup_regA != '0)
                && (r_reg[r_head + PW'(k)] == lookup_regA)) begin
                hit_A     = 1'b1;
                fwd_dataA = r_data[r_head + PW'(k)];
            end
            if (r_valid[r_head + PW'(k)] && (lookup_regB != '0)
                && (r_reg[r_head + PW'(k)] == lookup_regB)) begin
                hit_B     = 1'b1;
                fwd_dataB = r_data[r_head + PW'(k)];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
// ============================================================================
//  Module      : tb_regfile_write_queue
//  Description : Self-checking bench for regfile_write_queue; directed
//                scenarios plus random traffic against a queue-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        stall_drain;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  lookup_regA;
    logic [4:0]  lookup_regB;
    logic        hit_A;
    logic        hit_B;
    logic [31:0] fwd_dataA;
    logic [31:0] fwd_dataB;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;
    ent_t mq[$];

    regfile_write_queue #(.DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .stall_drain(stall_drain), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .lookup_regA(lookup_regA), .lookup_regB(lookup_regB),
        .hit_A(hit_A), .hit_B(hit_B), .fwd_dataA(fwd_dataA), .fwd_dataB(fwd_dataB),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clock = ~clock;

    // Reference model: the queue contents as a list, oldest first.
    function automatic bit m_ready();
        bit r;
        r = mq.size() < DEPTH;
`ifdef REGFILE_WQ_COALESCE_EN
        if (in_valid && mq.size() != 0 && mq[mq.size()-1].r == in_reg) r = 1'b1;
`endif
        return r;
    endfunction

    function automatic bit m_hit(input logic [4:0] lk);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (lk != 5'd0 && mq[i].r == lk) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] lk);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (lk != 5'd0 && mq[i].r == lk) return mq[i].d;
        return 32'd0;
    endfunction

    task automatic cycle();
        bit   pop, push, coal;
        ent_t e;
        pop  = (mq.size() != 0) && !stall_drain;
        coal = 1'b0;
`ifdef REGFILE_WQ_COALESCE_EN
        coal = in_valid && in_reg != 5'd0 && mq.size() != 0
               && mq[mq.size()-1].r == in_reg && !(pop && mq.size() == 1);
`endif
        push = in_valid && m_ready() && in_reg != 5'd0 && !coal;
        @(posedge clock);
        if (ctrl_reset) begin
            mq.delete();
        end else begin
            if (coal) begin
                e = mq[mq.size()-1];
                e.d = in_data;
                mq[mq.size()-1] = e;
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.r = in_reg;
                e.d = in_data;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
    endtask

    task automatic do_reset();
        ctrl_reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0);
        stall_drain = 1'b0;
        cycle();
        ctrl_reset = 1'b0;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        drive(1'b1, 5'd3, 32'h1111);
        stall_drain = 1'b0;
        cycle();
        ctrl_reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        lookup_regA = 5'd3;
        lookup_regB = 5'd3;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", in_ready); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin
            n_fail++; $display("FAIL reset_wport: got we=%0b reg=%0d data=%0h expected 0/0/0", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        n_checks++; if (hit_A !== 1'b0 || hit_B !== 1'b0 || fwd_dataA !== 32'd0 || fwd_dataB !== 32'd0) begin
            n_fail++; $display("FAIL reset_fwd: got hA=%0b hB=%0b fA=%0h fB=%0h expected all 0", hit_A, hit_B, fwd_dataA, fwd_dataB); end
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 5'd3, 32'hDEADBEEF);
        cycle();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_write: got we=%0b reg=%0d data=%0h expected 1/3/deadbeef", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        cycle();
        #1;
        n_checks++; if (empty !== 1'b1 || ctrl_writeEnable !== 1'b0) begin
            n_fail++; $display("FAIL single_drained: got empty=%0b we=%0b expected 1/0", empty, ctrl_writeEnable); end
    endtask

    task automatic test_fill();
        do_reset();
        stall_drain = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(32'h11 * i));
            cycle();
        end
        drive(1'b1, 5'd5, 32'h55);
        #1;
        n_checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
            n_fail++; $display("FAIL fill_full: got full=%0b ready=%0b count=%0d expected 1/0/4", full, in_ready, count); end
        cycle();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_fifth_ignored: got %0d expected 4", count); end
        stall_drain = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'(i) || data_writeReg !== 32'(32'h11 * i)) begin
                n_fail++; $display("FAIL fill_drain%0d: got we=%0b reg=%0d data=%0h expected 1/%0d/%0h", i, ctrl_writeEnable, ctrl_writeReg, data_writeReg, i, 32'h11 * i); end
            cycle();
        end
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_forward();
        logic [2:0]  exp_cnt;
        logic [31:0] exp_first;
`ifdef REGFILE_WQ_COALESCE_EN
        exp_cnt = 3'd1; exp_first = 32'hBBBB;
`else
        exp_cnt = 3'd2; exp_first = 32'hAAAA;
`endif
        do_reset();
        stall_drain = 1'b1;
        drive(1'b1, 5'd5, 32'hAAAA);
        cycle();
        drive(1'b1, 5'd5, 32'hBBBB);
        cycle();
        drive(1'b0, 5'd0, 32'd0);
        lookup_regA = 5'd5;
        lookup_regB = 5'd6;
        #1;
        n_checks++; if (hit_A !== 1'b1 || fwd_dataA !== 32'hBBBB) begin
            n_fail++; $display("FAIL fwd_A: got hit=%0b data=%0h expected 1/bbbb", hit_A, fwd_dataA); end
        n_checks++; if (hit_B !== 1'b0 || fwd_dataB !== 32'd0) begin
            n_fail++; $display("FAIL fwd_B: got hit=%0b data=%0h expected 0/0", hit_B, fwd_dataB); end
        n_checks++; if (count !== exp_cnt) begin n_fail++; $display("FAIL fwd_count: got %0d expected %0d", count, exp_cnt); end
        stall_drain = 1'b0;
        #1;
        n_checks++; if (data_writeReg !== exp_first) begin
            n_fail++; $display("FAIL fwd_order: got %0h expected %0h", data_writeReg, exp_first); end
        for (int i = 0; i < 3; i++) cycle();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fwd_drain_timeout: got empty=%0b expected 1", empty); end
    endtask

    task automatic test_reg_zero();
        do_reset();
        drive(1'b1, 5'd0, 32'h1234);
        lookup_regA = 5'd0;
        #1;
        n_checks++; if (in_ready !== 1'b1 || hit_A !== 1'b0) begin
            n_fail++; $display("FAIL zero_ready: got ready=%0b hitA=%0b expected 1/0", in_ready, hit_A); end
        cycle();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (count !== 3'd0 || ctrl_writeEnable !== 1'b0) begin
            n_fail++; $display("FAIL zero_discard: got count=%0d we=%0b expected 0/0", count, ctrl_writeEnable); end
    endtask

    task automatic test_back_to_back();
        int expq[$];
        do_reset();
        stall_drain = 1'b1;
        drive(1'b1, 5'd7, 32'h700); cycle();
        drive(1'b1, 5'd8, 32'h800); cycle();
        expq = {7, 8};
        stall_drain = 1'b0;
        for (int i = 0; i < 6; i++) begin
            int e;
            drive(1'b1, 5'(9 + i), 32'(32'h900 + i));
            #1;
            e = expq.pop_front();
            n_checks++; if (count !== 3'd2 || ctrl_writeReg !== 5'(e) || ctrl_writeEnable !== 1'b1) begin
                n_fail++; $display("FAIL b2b_%0d: got count=%0d reg=%0d we=%0b expected 2/%0d/1", i, count, ctrl_writeReg, ctrl_writeEnable, e); end
            expq.push_back(9 + i);
            cycle();
        end
        drive(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            int e;
            #1;
            e = expq.pop_front();
            n_checks++; if (ctrl_writeReg !== 5'(e)) begin
                n_fail++; $display("FAIL b2b_tail%0d: got %0d expected %0d", i, ctrl_writeReg, e); end
            cycle();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        stall_drain = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(10 + i), 32'(i + 1));
            cycle();
        end
        drive(1'b1, 5'd13, 32'h13);
        ctrl_reset = 1'b1;
        cycle();
        ctrl_reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        stall_drain = 1'b0;
        lookup_regA = 5'd10;
        lookup_regB = 5'd11;
        #1;
        n_checks++; if (count !== 3'd0 || ctrl_writeEnable !== 1'b0 || hit_A !== 1'b0 || hit_B !== 1'b0) begin
            n_fail++; $display("FAIL midreset: got count=%0d we=%0b hA=%0b hB=%0b expected 0/0/0/0", count, ctrl_writeEnable, hit_A, hit_B); end
    endtask

    task automatic test_random();
        logic [4:0]  e_reg;
        logic [31:0] e_dat;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ctrl_reset  = ($urandom_range(0, 99) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_reg      = 5'($urandom_range(0, 7));
            in_data     = $urandom;
            stall_drain = ($urandom_range(0, 3) == 0);
            lookup_regA = 5'($urandom_range(0, 7));
            lookup_regB = 5'($urandom_range(0, 7));
            #1;
            e_reg = (mq.size() != 0) ? mq[0].r : 5'd0;
            e_dat = (mq.size() != 0) ? mq[0].d : 32'd0;
            n_checks++; if (count !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                n_fail++; $display("FAIL rnd_occ c%0d: got count=%0d empty=%0b full=%0b expected count=%0d", c, count, empty, full, mq.size()); end
            n_checks++; if (in_ready !== m_ready()) begin
                n_fail++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", c, in_ready, m_ready()); end
            n_checks++; if (ctrl_writeEnable !== (mq.size() != 0 && !stall_drain) || ctrl_writeReg !== e_reg || data_writeReg !== e_dat) begin
                n_fail++; $display("FAIL rnd_wport c%0d: got we=%0b reg=%0d data=%0h expected reg=%0d data=%0h", c, ctrl_writeEnable, ctrl_writeReg, data_writeReg, e_reg, e_dat); end
            n_checks++; if (hit_A !== m_hit(lookup_regA) || fwd_dataA !== m_fwd(lookup_regA)) begin
                n_fail++; $display("FAIL rnd_fwdA c%0d: got hit=%0b data=%0h expected %0b/%0h", c, hit_A, fwd_dataA, m_hit(lookup_regA), m_fwd(lookup_regA)); end
            n_checks++; if (hit_B !== m_hit(lookup_regB) || fwd_dataB !== m_fwd(lookup_regB)) begin
                n_fail++; $display("FAIL rnd_fwdB c%0d: got hit=%0b data=%0h expected %0b/%0h", c, hit_B, fwd_dataB, m_hit(lookup_regB), m_fwd(lookup_regB)); end
            cycle();
        end
        ctrl_reset = 1'b0;
    endtask

    initial begin
        ctrl_reset  = 1'b1;
        stall_drain = 1'b0;
        lookup_regA = 5'd0;
        lookup_regB = 5'd0;
        drive(1'b0, 5'd0, 32'd0);
        cycle();
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_reg_zero();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
